// File: rtl/bcd2bin_pkg.sv
// Shared widths, state encoding and digit-validity helper for the BCD-to-binary converter.
package bcd2bin_pkg;

  localparam int DIGITS = 4;
  localparam int BCD_W  = 4 * DIGITS;
  localparam int BIN_W  = 14;
  localparam int ITER   = 14;
  localparam int CNT_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  // True when any nibble holds a non-decimal code (A-F).
  function automatic logic bcd_invalid(input logic [BCD_W-1:0] d);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (d[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/bcd_sub3_adj.sv
// Per-nibble correction for reverse double-dabble: a digit that is 8 or more
// after the right shift loses 3, so the digit stays decimal.
module bcd_sub3_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd8) ? din - 4'd3 : din;

endmodule

// File: rtl/bcd2bin.sv
// Sequential 4-digit BCD to 14-bit binary converter, 14 clocks per conversion,
// start/done handshake; invalid digits are flagged one clock after acceptance.
module bcd2bin
  import bcd2bin_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       bcd3,
  input  logic [3:0]       bcd2,
  input  logic [3:0]       bcd1,
  input  logic [3:0]       bcd0,
  output logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t             state;
  logic [BCD_W-1:0]   wb;
  logic [BIN_W-1:0]   wr;
  logic [CNT_W-1:0]   cnt;
  logic               err_pend;

  logic [BCD_W-1:0]       digits;
  logic [BCD_W+BIN_W-1:0] pair_sh;
  logic [BCD_W-1:0]       wb_sh;
  logic [BCD_W-1:0]       wb_adj;
  logic [BIN_W-1:0]       wr_sh;

  assign digits  = {bcd3, bcd2, bcd1, bcd0};
  assign pair_sh = {wb, wr} >> 1;
  assign wb_sh   = pair_sh[BCD_W+BIN_W-1:BIN_W];
  assign wr_sh   = pair_sh[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_sub3_adj u_adj (
      .din  (wb_sh[4*g +: 4]),
      .dout (wb_adj[4*g +: 4])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wb       <= '0;
      wr       <= '0;
      cnt      <= '0;
      err_pend <= 1'b0;
      bin      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;

      // Rejected request from the previous edge completes now.
      if (err_pend) begin
        err_pend <= 1'b0;
        done     <= 1'b1;
        err      <= 1'b1;
        bin      <= '0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            wb  <= digits;
            wr  <= '0;
            cnt <= '0;
            if (bcd_invalid(digits)) begin
              err_pend <= 1'b1;
            end else begin
              state <= CONV;
              busy  <= 1'b1;
            end
          end
        end
        CONV: begin
          wb  <= wb_adj;
          wr  <= wr_sh;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(ITER - 1)) begin
            bin   <= wr_sh;
            done  <= 1'b1;
            err   <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin.sv
// Randomized self-checking bench for bcd2bin against a decimal-arithmetic reference.
module tb_bcd2bin;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  bcd3 = '0, bcd2 = '0, bcd1 = '0, bcd0 = '0;
  logic [13:0] bin;
  logic        busy, done, err;

  int checks = 0;
  int errors = 0;

  bcd2bin dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .bcd3 (bcd3),
    .bcd2 (bcd2),
    .bcd1 (bcd1),
    .bcd0 (bcd0),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .err  (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Decimal value of four BCD digits, or -1 if any digit is not 0-9.
  function automatic int ref_val(input logic [15:0] d);
    int acc;
    int dig;
    acc = 0;
    for (int i = 3; i >= 0; i--) begin
      dig = int'(d[4*i +: 4]);
      if (dig > 9) return -1;
      acc = acc * 10 + dig;
    end
    return acc;
  endfunction

  task automatic set_digits(input logic [15:0] d);
    {bcd3, bcd2, bcd1, bcd0} = d;
  endtask

  // Returns at the sample point just after the accepting edge, start still high.
  task automatic launch(input logic [15:0] d);
    @(negedge clk);
    set_digits(d);
    start = 1'b1;
    @(negedge clk);
  endtask

  // Samples once per cycle until done; start follows pmask, digits switch to alt at sample 2.
  task automatic wait_done(input logic [31:0] pmask, input logic [15:0] alt,
                           output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      start = pmask[lat];
      if (lat == 2) set_digits(alt);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic conv_check(input string tag, input logic [15:0] d,
                            input logic [15:0] alt, input logic [31:0] pmask);
    int lat, bcnt, exp;
    launch(d);
    wait_done(pmask, alt, lat, bcnt);
    start = 1'b0;
    exp = ref_val(d);
    if (exp < 0) begin
      check({tag, ".bin"},  32'(bin), 0);
      check({tag, ".err"},  32'(err), 1);
      check({tag, ".lat"},  lat, 1);
      check({tag, ".busy"}, bcnt, 0);
    end else begin
      check({tag, ".bin"},  32'(bin), exp);
      check({tag, ".err"},  32'(err), 0);
      check({tag, ".lat"},  lat, 14);
      check({tag, ".busy"}, bcnt, 14);
    end
    check({tag, ".busy_at_done"}, 32'(busy), 0);
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(done), 0);
    check({tag, ".bin_hold"}, 32'(bin), (exp < 0) ? 0 : exp);
  endtask

  initial begin
    int lat, bcnt, seen;
    logic [15:0] d;

    repeat (2) @(negedge clk);
    check("rst.bin",  32'(bin), 0);
    check("rst.busy", 32'(busy), 0);
    check("rst.done", 32'(done), 0);
    check("rst.err",  32'(err), 0);
    rst = 1'b0;

    conv_check("zero", 16'h0000, 16'h0000, 0);
    conv_check("max",  16'h9999, 16'h9999, 0);
    conv_check("1234", 16'h1234, 16'h1234, 0);
    conv_check("9000", 16'h9000, 16'h9000, 0);
    conv_check("0009", 16'h0009, 16'h0009, 0);
    conv_check("bad",  16'h1A23, 16'h1A23, 0);
    conv_check("badF", 16'hF000, 16'hF000, 0);
    conv_check("ign",  16'h5678, 16'h5678, (32'd1 << 3) | (32'd1 << 10));
    conv_check("hold", 16'h4321, 16'h9999, 0);

    // start held through done: second request accepted in the done cycle
    launch(16'h5678);
    wait_done(32'hFFFF_FFFF, 16'h5678, lat, bcnt);
    check("b2b.first.bin", 32'(bin), 5678);
    check("b2b.first.lat", lat, 14);
    set_digits(16'h0012);
    @(negedge clk);
    wait_done(32'h0, 16'h0012, lat, bcnt);
    start = 1'b0;
    check("b2b.second.bin", 32'(bin), 12);
    check("b2b.second.lat", lat, 14);
    check("b2b.second.busy", bcnt, 14);

    // asynchronous reset between edges in the middle of a conversion
    launch(16'h4321);
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst.bin",  32'(bin), 0);
    check("arst.busy", 32'(busy), 0);
    check("arst.done", 32'(done), 0);
    check("arst.err",  32'(err), 0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("arst.no_done", seen, 0);
    conv_check("after_rst", 16'h0042, 16'h0042, 0);

    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 4; i++) d[4*i +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 9) == 0) d[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
      conv_check("rand", d, 16'($urandom), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
